// File: rtl/timer_pkg.sv
// Shared encodings for the countdown timer control block: FSM states,
// display-mode codes and the BCD digit range check.
package timer_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RUN   = 3'd1;
    localparam logic [2:0] ST_PAUSE = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_ERROR = 3'd4;

    localparam logic [1:0] DISP_NORMAL = 2'd0;
    localparam logic [1:0] DISP_PAUSED = 2'd1;
    localparam logic [1:0] DISP_DONE   = 2'd2;
    localparam logic [1:0] DISP_ERROR  = 2'd3;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic bcd_valid(input logic [3:0] tens, input logic [3:0] units);
        return (tens <= BCD_MAX) && (units <= BCD_MAX);
    endfunction

endpackage

// File: rtl/edge_det.sv
// Rising-edge detector for a debounced button level. The previous-value
// register resets high so a button held through reset never looks like a press.
module edge_det (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk) begin
        if (reset) prev <= 1'b1;
        else       prev <= btn;
    end

    assign rise = btn & ~prev;

endmodule

// File: rtl/timer_ctrl.sv
// Control FSM for the BCD countdown timer: turns button presses into load
// pulses and a gated count enable, and runs the timed end-of-count alarm.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int ALARM_SECS = 10,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_btn,
    input  logic       pause_btn,
    input  logic       load_btn,
    input  logic [3:0] min10,
    input  logic [3:0] min1,
    input  logic       tick,
    input  logic       is_zero,
    output logic       load,
    output logic       ce,
    output logic [2:0] state_o,
    output logic       run_led,
    output logic       alarm_led,
    output logic       error_led,
    output logic [1:0] disp_mode
);

    localparam logic [CNT_W-1:0] ALARM_INIT = CNT_W'(ALARM_SECS);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic start_edge, pause_edge, load_edge;

    edge_det u_start (.clk(clk), .reset(reset), .btn(start_btn), .rise(start_edge));
    edge_det u_pause (.clk(clk), .reset(reset), .btn(pause_btn), .rise(pause_edge));
    edge_det u_load  (.clk(clk), .reset(reset), .btn(load_btn),  .rise(load_edge));

    // Coincident presses resolve load > pause > start; only the winner acts.
    logic go_load, go_pause, go_start, any_edge, valid;
    assign go_load  = load_edge;
    assign go_pause = pause_edge & ~load_edge;
    assign go_start = start_edge & ~load_edge & ~pause_edge;
    assign any_edge = start_edge | pause_edge | load_edge;
    assign valid    = bcd_valid(min10, min1);

    logic [2:0]       state, state_nxt;
    logic             load_nxt, alarm_led_nxt;
    logic [CNT_W-1:0] alarm_cnt, alarm_cnt_nxt;

    always_comb begin
        state_nxt     = state;
        load_nxt      = 1'b0;
        alarm_led_nxt = alarm_led;
        alarm_cnt_nxt = alarm_cnt;
        case (state)
            ST_IDLE: begin
                if (go_load) begin
                    if (valid) load_nxt  = 1'b1;
                    else       state_nxt = ST_ERROR;
                end else if (go_start && !is_zero) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (go_pause) begin
                    state_nxt = ST_PAUSE;
                end else if (is_zero) begin
                    state_nxt     = ST_DONE;
                    alarm_cnt_nxt = ALARM_INIT;
                    alarm_led_nxt = 1'b1;
                end
            end
            ST_PAUSE: begin
                if (go_load) begin
                    if (valid) begin
                        load_nxt  = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_ERROR;
                    end
                end else if (go_pause || go_start) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_DONE: begin
                if (any_edge || (tick && alarm_cnt == CNT_ONE)) begin
                    state_nxt     = ST_IDLE;
                    alarm_led_nxt = 1'b0;
                    alarm_cnt_nxt = '0;
                end else if (tick) begin
                    alarm_led_nxt = ~alarm_led;
                    if (alarm_cnt != '0) alarm_cnt_nxt = alarm_cnt - CNT_ONE;
                end
            end
            ST_ERROR: begin
                if (go_load && valid) begin
                    load_nxt  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt     = ST_IDLE;
                alarm_led_nxt = 1'b0;
                alarm_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            load      <= 1'b0;
            alarm_led <= 1'b0;
            alarm_cnt <= '0;
        end else begin
            state     <= state_nxt;
            load      <= load_nxt;
            alarm_led <= alarm_led_nxt;
            alarm_cnt <= alarm_cnt_nxt;
        end
    end

    // tick/ce are single-cycle enables, not a handshake: ce is combinational
    // so a tick landing on the cycle the state changes is still honoured.
    assign ce = tick & (state == ST_RUN) & ~is_zero;

    assign state_o   = state;
    assign run_led   = (state == ST_RUN);
    assign error_led = (state == ST_ERROR);

    always_comb begin
        case (state)
            ST_PAUSE: disp_mode = DISP_PAUSED;
            ST_DONE:  disp_mode = DISP_DONE;
            ST_ERROR: disp_mode = DISP_ERROR;
            default:  disp_mode = DISP_NORMAL;
        endcase
    end

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl: each scenario queues stimulus rows and
// the expected output word, then replays them and compares at the falling edge.
module tb_timer_ctrl;
    import timer_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_btn = 1'b0, pause_btn = 1'b0, load_btn = 1'b0;
    logic [3:0] min10 = 4'd0, min1 = 4'd1;
    logic       tick = 1'b0, is_zero = 1'b0;
    logic       load, ce, run_led, alarm_led, error_led;
    logic [2:0] state_o;
    logic [1:0] disp_mode;

    timer_ctrl #(.ALARM_SECS(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .start_btn(start_btn), .pause_btn(pause_btn),
        .load_btn(load_btn), .min10(min10), .min1(min1), .tick(tick), .is_zero(is_zero),
        .load(load), .ce(ce), .state_o(state_o), .run_led(run_led),
        .alarm_led(alarm_led), .error_led(error_led), .disp_mode(disp_mode)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       r, s, p, l, t, z;
        logic [3:0] m10, m1;
    } stim_t;

    stim_t      stim_q[$];
    logic [9:0] exp_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    logic [3:0] cur_m10 = 4'd0, cur_m1 = 4'd1;

    function automatic stim_t mk(input logic r, s, p, l, t, z);
        return '{r: r, s: s, p: p, l: l, t: t, z: z, m10: cur_m10, m1: cur_m1};
    endfunction

    // Expected output word; led/disp values follow from the state as the block is specified.
    function automatic logic [9:0] ew(input logic [2:0] st, input logic ld, c, a);
        logic [1:0] d;
        d = (st == ST_PAUSE) ? 2'd1 : (st == ST_DONE) ? 2'd2 : (st == ST_ERROR) ? 2'd3 : 2'd0;
        return {st, ld, c, st == ST_RUN, a, st == ST_ERROR, d};
    endfunction

    function automatic logic [9:0] obs();
        return {state_o, load, ce, run_led, alarm_led, error_led, disp_mode};
    endfunction

    task automatic push(input stim_t s, input logic [9:0] e);
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    task automatic apply(input stim_t s);
        @(posedge clk);
        #1;
        reset = s.r; start_btn = s.s; pause_btn = s.p; load_btn = s.l;
        tick = s.t; is_zero = s.z; min10 = s.m10; min1 = s.m1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [9:0] got, exp;
        int idx = 0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        push(mk(1,0,0,0,0,0), ew(ST_IDLE,0,0,0));
        push(mk(0,0,0,0,0,0), ew(ST_IDLE,0,0,0));
        push(mk(0,0,0,0,1,0), ew(ST_IDLE,0,0,0));
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front());
            got = obs(); exp = exp_q.pop_front(); n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL reset[%0d]: got %b exp %b", idx, got, exp);
            end
            idx++;
        end
    endtask

    task automatic test_load_run();
        logic [9:0] got, exp;
        int idx = 0;
        cur_m10 = 4'd0; cur_m1 = 4'd1;
        push(mk(0,0,0,1,0,0), ew(ST_IDLE,0,0,0));
        push(mk(0,0,0,1,0,0), ew(ST_IDLE,1,0,0));
        push(mk(0,0,0,0,0,0), ew(ST_IDLE,0,0,0));
        push(mk(0,1,0,0,0,0), ew(ST_IDLE,0,0,0));
        push(mk(0,1,0,0,0,0), ew(ST_RUN,0,0,0));
        for (int i = 0; i < 60; i++) begin
            push(mk(0,0,0,0,1,0), ew(ST_RUN,0,1,0));
            push(mk(0,0,0,0,0,0), ew(ST_RUN,0,0,0));
        end
        push(mk(0,0,0,0,1,1), ew(ST_RUN,0,0,0));
        push(mk(0,0,0,0,0,1), ew(ST_DONE,0,0,1));
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front());
            got = obs(); exp = exp_q.pop_front(); n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL load_run[%0d]: got %b exp %b", idx, got, exp);
            end
            idx++;
        end
    endtask

    task automatic test_alarm_timeout();
        logic [9:0] got, exp;
        int idx = 0;
        push(mk(0,0,0,0,1,1), ew(ST_DONE,0,0,1));
        push(mk(0,0,0,0,0,1), ew(ST_DONE,0,0,0));
        push(mk(0,0,0,0,1,1), ew(ST_DONE,0,0,0));
        push(mk(0,0,0,0,0,1), ew(ST_DONE,0,0,1));
        push(mk(0,0,0,0,1,1), ew(ST_DONE,0,0,1));
        push(mk(0,0,0,0,0,1), ew(ST_DONE,0,0,0));
        push(mk(0,0,0,0,1,1), ew(ST_DONE,0,0,0));
        push(mk(0,0,0,0,0,1), ew(ST_IDLE,0,0,0));
        push(mk(0,0,0,0,0,1), ew(ST_IDLE,0,0,0));
        // Second pass: a pause press after two alarm ticks ends the alarm at once.
        push(mk(0,1,0,0,0,0), ew(ST_IDLE,0,0,0));
        push(mk(0,0,0,0,0,1), ew(ST_RUN,0,0,0));
        push(mk(0,0,0,0,0,1), ew(ST_DONE,0,0,1));
        push(mk(0,0,0,0,1,1), ew(ST_DONE,0,0,1));
        push(mk(0,0,0,0,0,1), ew(ST_DONE,0,0,0));
        push(mk(0,0,0,0,1,1), ew(ST_DONE,0,0,0));
        push(mk(0,0,0,0,0,1), ew(ST_DONE,0,0,1));
        push(mk(0,0,1,0,0,1), ew(ST_DONE,0,0,1));
        push(mk(0,0,1,0,0,1), ew(ST_IDLE,0,0,0));
        push(mk(0,0,0,0,0,1), ew(ST_IDLE,0,0,0));
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front());
            got = obs(); exp = exp_q.pop_front(); n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL alarm_timeout[%0d]: got %b exp %b", idx, got, exp);
            end
            idx++;
        end
    endtask

    task automatic test_pause_resume();
        logic [9:0] got, exp;
        int idx = 0;
        push(mk(0,1,0,0,0,0), ew(ST_IDLE,0,0,0));
        push(mk(0,0,0,0,0,0), ew(ST_RUN,0,0,0));
        push(mk(0,0,0,0,1,0), ew(ST_RUN,0,1,0));
        push(mk(0,0,1,0,0,0), ew(ST_RUN,0,0,0));
        push(mk(0,0,0,0,0,0), ew(ST_PAUSE,0,0,0));
        for (int i = 0; i < 5; i++) begin
            push(mk(0,0,0,0,1,0), ew(ST_PAUSE,0,0,0));
            push(mk(0,0,0,0,0,0), ew(ST_PAUSE,0,0,0));
        end
        push(mk(0,1,0,0,0,0), ew(ST_PAUSE,0,0,0));
        push(mk(0,0,0,0,1,0), ew(ST_RUN,0,1,0));
        push(mk(0,0,0,0,0,0), ew(ST_RUN,0,0,0));
        push(mk(0,0,1,0,0,0), ew(ST_RUN,0,0,0));
        push(mk(0,0,0,0,0,0), ew(ST_PAUSE,0,0,0));
        push(mk(0,0,1,0,0,0), ew(ST_PAUSE,0,0,0));
        push(mk(0,0,0,0,0,0), ew(ST_RUN,0,0,0));
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front());
            got = obs(); exp = exp_q.pop_front(); n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL pause_resume[%0d]: got %b exp %b", idx, got, exp);
            end
            idx++;
        end
    endtask

    task automatic test_simultaneous();
        logic [9:0] got, exp;
        int idx = 0;
        cur_m10 = 4'd0; cur_m1 = 4'd1;
        push(mk(0,0,1,0,0,0), ew(ST_RUN,0,0,0));
        push(mk(0,0,0,0,0,0), ew(ST_PAUSE,0,0,0));
        push(mk(0,1,0,1,0,0), ew(ST_PAUSE,0,0,0));
        push(mk(0,0,0,0,0,0), ew(ST_IDLE,1,0,0));
        push(mk(0,0,0,0,0,0), ew(ST_IDLE,0,0,0));
        // Pause outranks start in IDLE, so the start press is dropped.
        push(mk(0,1,1,0,0,0), ew(ST_IDLE,0,0,0));
        push(mk(0,0,0,0,0,0), ew(ST_IDLE,0,0,0));
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front());
            got = obs(); exp = exp_q.pop_front(); n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL simultaneous[%0d]: got %b exp %b", idx, got, exp);
            end
            idx++;
        end
    endtask

    task automatic test_invalid();
        logic [9:0] got, exp;
        int idx = 0;
        cur_m10 = 4'd0; cur_m1 = 4'hA;
        push(mk(0,0,0,1,0,0), ew(ST_IDLE,0,0,0));
        push(mk(0,0,0,0,0,0), ew(ST_ERROR,0,0,0));
        push(mk(0,1,0,0,0,0), ew(ST_ERROR,0,0,0));
        push(mk(0,0,0,0,1,0), ew(ST_ERROR,0,0,0));
        push(mk(0,0,1,0,0,0), ew(ST_ERROR,0,0,0));
        push(mk(0,0,0,1,0,0), ew(ST_ERROR,0,0,0));
        push(mk(0,0,0,0,0,0), ew(ST_ERROR,0,0,0));
        cur_m1 = 4'd3;
        push(mk(0,0,0,1,0,0), ew(ST_ERROR,0,0,0));
        push(mk(0,0,0,0,0,0), ew(ST_IDLE,1,0,0));
        push(mk(0,0,0,0,0,0), ew(ST_IDLE,0,0,0));
        cur_m10 = 4'hA; cur_m1 = 4'd0;
        push(mk(0,0,0,1,0,0), ew(ST_IDLE,0,0,0));
        push(mk(0,0,0,0,0,0), ew(ST_ERROR,0,0,0));
        cur_m10 = 4'd9; cur_m1 = 4'd9;
        push(mk(0,0,0,1,0,0), ew(ST_ERROR,0,0,0));
        push(mk(0,0,0,0,0,0), ew(ST_IDLE,1,0,0));
        push(mk(0,0,0,0,0,0), ew(ST_IDLE,0,0,0));
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front());
            got = obs(); exp = exp_q.pop_front(); n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL invalid[%0d]: got %b exp %b", idx, got, exp);
            end
            idx++;
        end
    endtask

    task automatic test_held_reset();
        logic [9:0] got, exp;
        int idx = 0;
        cur_m10 = 4'd0; cur_m1 = 4'd1;
        push(mk(1,1,0,0,0,0), ew(ST_IDLE,0,0,0));
        push(mk(1,1,0,0,0,0), ew(ST_IDLE,0,0,0));
        push(mk(0,1,0,0,0,0), ew(ST_IDLE,0,0,0));
        push(mk(0,1,0,0,0,0), ew(ST_IDLE,0,0,0));
        push(mk(0,0,0,0,0,0), ew(ST_IDLE,0,0,0));
        push(mk(0,1,0,0,0,0), ew(ST_IDLE,0,0,0));
        push(mk(0,1,0,0,0,0), ew(ST_RUN,0,0,0));
        // Reset in RUN returns to IDLE on the next edge.
        push(mk(1,0,0,0,1,0), ew(ST_RUN,0,1,0));
        push(mk(0,0,0,0,1,0), ew(ST_IDLE,0,0,0));
        push(mk(0,0,0,0,0,0), ew(ST_IDLE,0,0,0));
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front());
            got = obs(); exp = exp_q.pop_front(); n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL held_reset[%0d]: got %b exp %b", idx, got, exp);
            end
            idx++;
        end
    endtask

    task automatic test_boundary();
        logic [9:0] got, exp;
        int idx = 0;
        push(mk(0,1,0,0,1,1), ew(ST_IDLE,0,0,0));
        push(mk(0,0,0,0,1,1), ew(ST_IDLE,0,0,0));
        push(mk(0,0,0,0,0,1), ew(ST_IDLE,0,0,0));
        for (int i = 0; i < 3; i++) begin
            push(mk(0,0,0,0,1,1), ew(ST_IDLE,0,0,0));
            push(mk(0,0,0,0,0,1), ew(ST_IDLE,0,0,0));
        end
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front());
            got = obs(); exp = exp_q.pop_front(); n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL boundary[%0d]: got %b exp %b", idx, got, exp);
            end
            idx++;
        end
    endtask

    initial begin
        test_reset();
        test_load_run();
        test_alarm_timeout();
        test_pause_resume();
        test_simultaneous();
        test_invalid();
        test_held_reset();
        test_boundary();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
